// File: rtl/display_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-seg display: digit scan,
// blanking gap, per-digit enable, PWM brightness and frame-synced data.
module display_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] hexs_in,
  input  logic [3:0]  points_in,
  input  logic [3:0]  les_in,
  input  logic [3:0]  en_mask,
  input  logic [3:0]  bright,
  output logic [1:0]  scan,
  output logic [3:0]  AN,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic        pending,
  output logic        frame_tick
);

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_e;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       scan_q, scan_d;
  logic [3:0]       pwm_q, pwm_d;
  logic [3:0]       en_q, en_d;
  logic [3:0]       bright_q, bright_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q, tick_d;
  logic [15:0]      sh_hex_q, sh_hex_d;
  logic [3:0]       sh_pts_q, sh_pts_d;
  logic [3:0]       sh_les_q, sh_les_d;
  logic [15:0]      hex_q, hex_d;
  logic [3:0]       pts_q, pts_d;
  logic [3:0]       les_q, les_d;
  logic             pend_q, pend_d;
  logic             wrap;
  phase_e           phase_d;

  // AN is computed from next-state values so it always matches scan
  always_comb begin
    wrap       = (slot_cnt_q == LAST);
    slot_cnt_d = wrap ? '0 : slot_cnt_q + 1'b1;
    scan_d     = wrap ? scan_q + 2'd1 : scan_q;
    pwm_d      = wrap ? 4'd0 : pwm_q + 4'd1;
    en_d       = (slot_cnt_q == '0) ? en_mask : en_q;
    bright_d   = (slot_cnt_q == '0) ? bright : bright_q;
    tick_d     = wrap && (scan_q == 2'd3);
    phase_d    = (slot_cnt_d < BLANK) ? PH_BLANK : PH_ON;
    an_d       = 4'b1111;
    unique case (phase_d)
      PH_BLANK: an_d = 4'b1111;
      PH_ON: begin
        if (en_d[scan_d] && (pwm_d <= bright_d))
          an_d = ~(4'b0001 << scan_d);
      end
      default: an_d = 4'b1111;
    endcase
  end

  // Shadow is committed in the cycle after the wrap; a load in that
  // same cycle bypasses the shadow
  always_comb begin
    sh_hex_d = sh_hex_q;
    sh_pts_d = sh_pts_q;
    sh_les_d = sh_les_q;
    hex_d    = hex_q;
    pts_d    = pts_q;
    les_d    = les_q;
    pend_d   = pend_q;
    if (load) begin
      sh_hex_d = hexs_in;
      sh_pts_d = points_in;
      sh_les_d = les_in;
    end
    if (tick_q) begin
      if (load) begin
        hex_d  = hexs_in;
        pts_d  = points_in;
        les_d  = les_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        hex_d  = sh_hex_q;
        pts_d  = sh_pts_q;
        les_d  = sh_les_q;
        pend_d = 1'b0;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      scan_q     <= '0;
      pwm_q      <= '0;
      en_q       <= '0;
      bright_q   <= '0;
      an_q       <= 4'b1111;
      tick_q     <= 1'b0;
      sh_hex_q   <= '0;
      sh_pts_q   <= '0;
      sh_les_q   <= '0;
      hex_q      <= '0;
      pts_q      <= '0;
      les_q      <= '0;
      pend_q     <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      scan_q     <= scan_d;
      pwm_q      <= pwm_d;
      en_q       <= en_d;
      bright_q   <= bright_d;
      an_q       <= an_d;
      tick_q     <= tick_d;
      sh_hex_q   <= sh_hex_d;
      sh_pts_q   <= sh_pts_d;
      sh_les_q   <= sh_les_d;
      hex_q      <= hex_d;
      pts_q      <= pts_d;
      les_q      <= les_d;
      pend_q     <= pend_d;
    end
  end

  assign scan       = scan_q;
  assign AN         = an_q;
  assign hexs       = hex_q;
  assign points     = pts_q;
  assign LEs        = les_q;
  assign pending    = pend_q;
  assign frame_tick = tick_q;

endmodule
